// File: rtl/specinvert_pkg.sv
// Shared types and register map for the specinvert spectrum-inversion detector.
// Imported by the detector top and its cross-product multiplier.
package specinvert_pkg;

  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h04;
  localparam logic [7:0] REG_THRESH = 8'h08;
  localparam logic [7:0] REG_WINDOW = 8'h0C;

  localparam int CTRL_INVERT     = 0;
  localparam int CTRL_AUTODETECT = 1;

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] i;
  } sc16_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_ACCUM
  } det_state_t;

endpackage

// File: rtl/sc16_cross_mult.sv
// Two-stage pipeline: register a sample pair, then form both cross products.
// The tag rides alongside so the caller can mark window-closing beats.
module sc16_cross_mult
  import specinvert_pkg::*;
#(
  parameter int TAG_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_valid,
  input  sc16_t             i_cur,
  input  sc16_t             i_prev,
  input  logic [TAG_W-1:0]  i_tag,
  output logic              o_valid,
  output logic signed [31:0] o_p_iq,
  output logic signed [31:0] o_p_qi,
  output logic [TAG_W-1:0]  o_tag
);

  sc16_t            r_cur;
  sc16_t            r_prev;
  logic             r_v;
  logic [TAG_W-1:0] r_tag;

  logic signed [31:0] w_pi;
  logic signed [31:0] w_pq;
  logic signed [31:0] w_ci;
  logic signed [31:0] w_cq;

  assign w_pi = $signed({{16{r_prev.i[15]}}, r_prev.i});
  assign w_pq = $signed({{16{r_prev.q[15]}}, r_prev.q});
  assign w_ci = $signed({{16{r_cur.i[15]}}, r_cur.i});
  assign w_cq = $signed({{16{r_cur.q[15]}}, r_cur.q});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur   <= '0;
      r_prev  <= '0;
      r_v     <= 1'b0;
      r_tag   <= '0;
      o_valid <= 1'b0;
      o_p_iq  <= '0;
      o_p_qi  <= '0;
      o_tag   <= '0;
    end else begin
      r_v     <= i_valid & ~i_flush;
      o_valid <= r_v & ~i_flush;
      if (i_valid) begin
        r_cur  <= i_cur;
        r_prev <= i_prev;
        r_tag  <= i_tag;
      end
      if (r_v) begin
        o_p_iq <= w_pi * w_cq;
        o_p_qi <= w_pq * w_ci;
        o_tag  <= r_tag;
      end
    end
  end

endmodule

// File: rtl/specinvert_detector.sv
// Spectrum-inversion detector: windowed, saturating sum of I/Q cross products
// on tapped AXI-Stream beats, with a hysteresis threshold decision.
module specinvert_detector
  import specinvert_pkg::*;
#(
  parameter int ITEM_W = 32,
  parameter int ACC_W  = 48
) (
  input  logic                    ce_clk,
  input  logic                    ce_rst_n,
  input  logic [ITEM_W-1:0]       tap_tdata,
  input  logic                    tap_tvalid,
  input  logic                    tap_tready,
  input  logic                    cfg_enable,
  input  logic [31:0]             cfg_threshold,
  input  logic [31:0]             cfg_window,
  output logic                    det_valid,
  output logic                    det_inverted,
  output logic signed [ACC_W-1:0] det_metric,
  output logic                    det_busy
);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  det_state_t r_state;
  sc16_t      r_prev;
  logic [31:0] r_win;
  logic [31:0] r_thr;
  logic [31:0] r_cnt;

  logic        w_beat;
  logic        w_fire;
  logic        w_last;
  logic [31:0] w_cnt_nxt;
  sc16_t       w_item;

  assign w_item    = sc16_t'(tap_tdata[31:0]);
  assign w_beat    = tap_tvalid & tap_tready;
  assign w_cnt_nxt = r_cnt + 32'd1;
  assign w_last    = (w_cnt_nxt == r_win);
  assign w_fire    = w_beat & cfg_enable & (r_state == ST_ACCUM);

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      r_state <= ST_IDLE;
      r_prev  <= '0;
      r_win   <= '0;
      r_thr   <= '0;
      r_cnt   <= '0;
    end else if (!cfg_enable) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cfg_window != 32'd0) begin
            r_state <= ST_PRIME;
            r_win   <= cfg_window;
            r_thr   <= cfg_threshold;
          end
        end
        ST_PRIME: begin
          if (w_beat) begin
            r_prev  <= w_item;
            r_cnt   <= '0;
            r_state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (w_beat) begin
            r_prev <= w_item;
            if (w_last) begin
              // Shadow config reloads here; predecessor carries over.
              r_cnt <= '0;
              r_win <= cfg_window;
              r_thr <= cfg_threshold;
              if (cfg_window == 32'd0) r_state <= ST_IDLE;
            end else begin
              r_cnt <= w_cnt_nxt;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  logic               w_p_v;
  logic signed [31:0] w_p_iq;
  logic signed [31:0] w_p_qi;
  logic [32:0]        w_p_tag;

  sc16_cross_mult #(
    .TAG_W (33)
  ) u_mult (
    .clk     (ce_clk),
    .rst_n   (ce_rst_n),
    .i_flush (~cfg_enable),
    .i_valid (w_fire),
    .i_cur   (w_item),
    .i_prev  (r_prev),
    .i_tag   ({w_last, r_thr}),
    .o_valid (w_p_v),
    .o_p_iq  (w_p_iq),
    .o_p_qi  (w_p_qi),
    .o_tag   (w_p_tag)
  );

  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_fin;
  logic [31:0]             r_fin_thr;
  logic                    r_fin_v;

  logic [32:0]        w_c;
  logic [ACC_W:0]     w_sum;
  logic [ACC_W-1:0]   w_sat;

  assign w_c   = {w_p_iq[31], w_p_iq} - {w_p_qi[31], w_p_qi};
  assign w_sum = {r_acc[ACC_W-1], r_acc}
               + {{(ACC_W-32){w_c[32]}}, w_c};

  always_comb begin
    w_sat = w_sum[ACC_W-1:0];
    if (w_sum[ACC_W] != w_sum[ACC_W-1]) begin
      w_sat = w_sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      r_acc     <= '0;
      r_fin     <= '0;
      r_fin_thr <= '0;
      r_fin_v   <= 1'b0;
    end else if (!cfg_enable) begin
      r_acc   <= '0;
      r_fin_v <= 1'b0;
    end else begin
      r_fin_v <= 1'b0;
      if (w_p_v) begin
        if (w_p_tag[32]) begin
          r_fin     <= w_sat;
          r_fin_thr <= w_p_tag[31:0];
          r_fin_v   <= 1'b1;
          r_acc     <= '0;
        end else begin
          r_acc <= w_sat;
        end
      end
    end
  end

  logic signed [ACC_W-1:0] w_thr_ext;
  assign w_thr_ext = {{(ACC_W-32){1'b0}}, r_fin_thr};

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      det_valid    <= 1'b0;
      det_inverted <= 1'b0;
      det_metric   <= '0;
    end else if (!cfg_enable) begin
      det_valid <= 1'b0;
    end else begin
      det_valid <= r_fin_v;
      if (r_fin_v) begin
        det_metric <= r_fin;
        if (r_fin > w_thr_ext) begin
          det_inverted <= 1'b0;
        end else if (r_fin < -w_thr_ext) begin
          det_inverted <= 1'b1;
        end
      end
    end
  end

  assign det_busy = (r_state != ST_IDLE) & ~det_valid;

endmodule

// File: tb/tb_specinvert_detector.sv
// Bench for specinvert_detector: spec-level window model, sinusoid,
// constant, abort, random-stall, reset and saturation scenarios.
module tb_specinvert_detector;

  logic        ce_clk = 1'b0;
  logic        ce_rst_n = 1'b0;
  logic [31:0] tap_tdata = '0;
  logic        tap_tvalid = 1'b0;
  logic        tap_tready = 1'b0;
  logic        cfg_enable = 1'b0;
  logic [31:0] cfg_threshold = '0;
  logic [31:0] cfg_window = '0;
  logic        det_valid;
  logic        det_inverted;
  logic        det_busy;
  logic [47:0] det_metric;

  specinvert_detector #(
    .ITEM_W (32),
    .ACC_W  (48)
  ) dut (
    .ce_clk        (ce_clk),
    .ce_rst_n      (ce_rst_n),
    .tap_tdata     (tap_tdata),
    .tap_tvalid    (tap_tvalid),
    .tap_tready    (tap_tready),
    .cfg_enable    (cfg_enable),
    .cfg_threshold (cfg_threshold),
    .cfg_window    (cfg_window),
    .det_valid     (det_valid),
    .det_inverted  (det_inverted),
    .det_metric    (det_metric),
    .det_busy      (det_busy)
  );

  always #5 ce_clk = ~ce_clk;

  int errors = 0;
  int checks = 0;
  longint cyc = 0;

  localparam longint AMAX = 64'sd140737488355327;
  localparam longint AMIN = -64'sd140737488355328;

  typedef struct {
    longint due;
    longint metric;
    longint thr;
  } dec_t;

  dec_t    q[$];
  int      m_st = 0;
  shortint m_pi = 0;
  shortint m_pq = 0;
  longint  m_acc = 0;
  longint  m_cnt = 0;
  longint  m_win = 0;
  longint  m_thr = 0;
  longint  m_metric = 0;
  logic    m_valid = 1'b0;
  logic    m_inv = 1'b0;

  task automatic model_step(input logic beat, input logic [31:0] d);
    dec_t e;
    longint c;
    m_valid = 1'b0;
    if (!ce_rst_n) begin
      q.delete();
      m_st = 0; m_inv = 1'b0; m_metric = 0; m_acc = 0; m_cnt = 0;
    end else if (!cfg_enable) begin
      q.delete();
      m_st = 0; m_acc = 0;
    end else begin
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        m_valid = 1'b1;
        m_metric = e.metric;
        if (e.metric > e.thr) m_inv = 1'b0;
        else if (e.metric < -e.thr) m_inv = 1'b1;
      end
      case (m_st)
        0: if (cfg_window != 0) begin
          m_st = 1; m_win = cfg_window; m_thr = cfg_threshold;
        end
        1: if (beat) begin
          m_pi = shortint'(d[15:0]); m_pq = shortint'(d[31:16]);
          m_st = 2; m_cnt = 0; m_acc = 0;
        end
        default: if (beat) begin
          c = longint'(m_pi) * longint'(shortint'(d[31:16]))
            - longint'(m_pq) * longint'(shortint'(d[15:0]));
          m_acc = m_acc + c;
          if (m_acc > AMAX) m_acc = AMAX;
          if (m_acc < AMIN) m_acc = AMIN;
          m_pi = shortint'(d[15:0]); m_pq = shortint'(d[31:16]);
          m_cnt++;
          if (m_cnt == m_win) begin
            q.push_back('{cyc + 3, m_acc, m_thr});
            m_acc = 0; m_cnt = 0;
            m_win = cfg_window; m_thr = cfg_threshold;
            if (cfg_window == 0) m_st = 0;
          end
        end
      endcase
    end
  endtask

  function automatic logic [50:0] exp_vec();
    logic busy;
    busy = (m_st != 0) && !m_valid;
    return {m_valid, m_inv, busy, m_metric[47:0]};
  endfunction

  task automatic tick(input logic v, input logic r, input logic [31:0] d);
    tap_tvalid = v; tap_tready = r; tap_tdata = d;
    @(posedge ce_clk);
    cyc++;
    model_step(v & r, d);
    @(negedge ce_clk);
  endtask

  function automatic logic [31:0] sine(int n, int sgn);
    real ph;
    shortint si;
    shortint sq;
    ph = 2.0 * 3.14159265358979 * real'(n) / 64.0;
    si = shortint'($rtoi(22937.0 * $cos(ph)));
    sq = shortint'($rtoi(real'(sgn) * 22937.0 * $sin(ph)));
    return {sq, si};
  endfunction

  task automatic restart(input int win, input int thr);
    cfg_enable = 1'b0;
    tick(0, 0, 0);
    cfg_window = win; cfg_threshold = thr; cfg_enable = 1'b1;
    tick(0, 0, 0);
  endtask

  task automatic test_reset();
    ce_rst_n = 1'b0; cfg_enable = 1'b1; cfg_window = 8;
    for (int k = 0; k < 4; k++) tick(1, 1, $urandom);
    checks++; if (det_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", det_valid); end
    checks++; if (det_inverted !== 1'b0) begin errors++; $display("FAIL rst_inv got=%b exp=0", det_inverted); end
    checks++; if (det_metric !== 48'd0) begin errors++; $display("FAIL rst_metric got=%h exp=0", det_metric); end
    checks++; if (det_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", det_busy); end
    cfg_enable = 1'b0;
    ce_rst_n = 1'b1;
    tick(0, 0, 0);
  endtask

  task automatic test_positive();
    int pulses = 0;
    restart(64, 1000000000);
    for (int n = 0; n < 263; n++) begin
      if (n < 257) tick(1, 1, sine(n, 1)); else tick(0, 1, 0);
      checks++;
      if ({det_valid, det_inverted, det_busy, det_metric} !== exp_vec()) begin
        errors++;
        $display("FAIL pos_cycle c=%0d got=%h exp=%h", cyc, {det_valid, det_inverted, det_busy, det_metric}, exp_vec());
      end
      if (det_valid) begin
        pulses++;
        checks++;
        if (det_inverted !== 1'b0 || $signed(det_metric) < 64'sd3000000000 || $signed(det_metric) > 64'sd3600000000) begin
          errors++;
          $display("FAIL pos_decision inv=%b metric=%0d exp inv=0 metric~3.3e9", det_inverted, $signed(det_metric));
        end
      end
    end
    checks++;
    if (pulses != 4) begin errors++; $display("FAIL pos_pulses got=%0d exp=4", pulses); end
  endtask

  task automatic test_negative();
    int pulses = 0;
    restart(64, 1000000000);
    for (int n = 0; n < 72; n++) begin
      if (n < 65) tick(1, 1, sine(n, -1)); else tick(0, 0, 0);
      checks++;
      if ({det_valid, det_inverted, det_busy, det_metric} !== exp_vec()) begin
        errors++;
        $display("FAIL neg_cycle c=%0d got=%h exp=%h", cyc, {det_valid, det_inverted, det_busy, det_metric}, exp_vec());
      end
      if (det_valid) begin
        pulses++;
        checks++;
        if (det_inverted !== 1'b1 || $signed(det_metric) > -64'sd3000000000 || $signed(det_metric) < -64'sd3600000000) begin
          errors++;
          $display("FAIL neg_decision inv=%b metric=%0d exp inv=1 metric~-3.3e9", det_inverted, $signed(det_metric));
        end
      end
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL neg_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_constant();
    int pulses = 0;
    restart(64, 1000000000);
    for (int n = 0; n < 72; n++) begin
      tick(n < 65, 1, {16'd0, 16'd1000});
      checks++;
      if ({det_valid, det_inverted, det_busy, det_metric} !== exp_vec()) begin
        errors++;
        $display("FAIL const_cycle c=%0d got=%h exp=%h", cyc, {det_valid, det_inverted, det_busy, det_metric}, exp_vec());
      end
      if (det_valid) begin
        pulses++;
        checks++;
        if (det_metric !== 48'd0 || det_inverted !== 1'b1) begin
          errors++;
          $display("FAIL const_decision inv=%b metric=%h exp inv=1 metric=0", det_inverted, det_metric);
        end
      end
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL const_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_abort();
    int pulses = 0;
    longint last_beat = 0;
    longint pulse_at = -1;
    restart(64, 1000);
    for (int n = 0; n < 30; n++) tick(1, 1, $urandom);
    cfg_enable = 1'b0;
    tick(1, 1, $urandom);
    cfg_enable = 1'b1;
    for (int n = 0; n < 76; n++) begin
      if (n >= 1 && n <= 65) tick(1, 1, $urandom); else tick(0, 0, 0);
      if (n == 65) last_beat = cyc;
      checks++;
      if ({det_valid, det_inverted, det_busy, det_metric} !== exp_vec()) begin
        errors++;
        $display("FAIL abort_cycle c=%0d got=%h exp=%h", cyc, {det_valid, det_inverted, det_busy, det_metric}, exp_vec());
      end
      if (det_valid) begin pulses++; pulse_at = cyc; end
    end
    checks++;
    if (pulses != 1 || pulse_at != last_beat + 3) begin
      errors++;
      $display("FAIL abort_timing pulses=%0d at=%0d exp 1 at %0d", pulses, pulse_at, last_beat + 3);
    end
  endtask

  task automatic test_random_stall();
    int wins [4] = '{1, 2, 7, 13};
    restart(0, 0);
    for (int k = 0; k < 10; k++) begin
      tick(1, 1, $urandom);
      checks++;
      if (det_busy !== 1'b0 || det_valid !== 1'b0) begin
        errors++;
        $display("FAIL win0_idle busy=%b valid=%b exp 0 0", det_busy, det_valid);
      end
    end
    for (int w = 0; w < 4; w++) begin
      restart(wins[w], $urandom_range(0, 2000000000));
      for (int n = 0; n < 300; n++) begin
        if ($urandom_range(0, 31) == 0) cfg_window = $urandom_range(1, 9);
        if ($urandom_range(0, 15) == 0) cfg_threshold = $urandom_range(0, 2000000000);
        cfg_enable = ($urandom_range(0, 63) != 0);
        tick($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom);
        checks++;
        if ({det_valid, det_inverted, det_busy, det_metric} !== exp_vec()) begin
          errors++;
          $display("FAIL rand_cycle w=%0d c=%0d got=%h exp=%h", w, cyc, {det_valid, det_inverted, det_busy, det_metric}, exp_vec());
        end
      end
    end
  endtask

  task automatic test_reset_midwindow();
    longint rel = 0;
    longint first = -1;
    restart(16, 100);
    for (int n = 0; n < 12; n++) tick($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom);
    ce_rst_n = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick(1, 1, $urandom);
      checks++;
      if ({det_valid, det_inverted, det_busy, det_metric} !== 51'd0) begin
        errors++;
        $display("FAIL rst_mid_zero got=%h exp=0", {det_valid, det_inverted, det_busy, det_metric});
      end
    end
    ce_rst_n = 1'b1;
    rel = cyc;
    for (int n = 0; n < 200; n++) begin
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom);
      checks++;
      if ({det_valid, det_inverted, det_busy, det_metric} !== exp_vec()) begin
        errors++;
        $display("FAIL rst_mid_cycle c=%0d got=%h exp=%h", cyc, {det_valid, det_inverted, det_busy, det_metric}, exp_vec());
      end
      if (det_valid && first < 0) first = cyc;
    end
    checks++;
    if (first < 0 || first - rel < 21) begin
      errors++;
      $display("FAIL rst_mid_first first=%0d rel=%0d exp >= rel+21", first, rel);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] ph [4];
    int pulses = 0;
    ph[0] = {16'sd32767, 16'sd32767};
    ph[1] = {16'sd32767, -16'sd32767};
    ph[2] = {-16'sd32767, -16'sd32767};
    ph[3] = {-16'sd32767, 16'sd32767};
    restart(66000, 1000000000);
    for (int n = 0; n < 66006; n++) begin
      if (n <= 66000) tick(1, 1, ph[n % 4]); else tick(0, 0, 0);
      checks++;
      if ({det_valid, det_inverted, det_busy, det_metric} !== exp_vec()) begin
        errors++;
        $display("FAIL sat_cycle c=%0d got=%h exp=%h", cyc, {det_valid, det_inverted, det_busy, det_metric}, exp_vec());
      end
      if (det_valid) begin
        pulses++;
        checks++;
        if (det_metric !== 48'h7FFF_FFFF_FFFF || det_inverted !== 1'b0) begin
          errors++;
          $display("FAIL sat_decision metric=%h inv=%b exp 7fffffffffff 0", det_metric, det_inverted);
        end
      end
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL sat_pulses got=%0d exp=1", pulses); end
  endtask

  initial begin
    test_reset();
    test_positive();
    test_negative();
    test_constant();
    test_abort();
    test_random_stall();
    test_reset_midwindow();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
